// File: rtl/dmem_mmio_pkg.sv
// dmem_mmio_pkg
//   Shared constants and helpers for the data-memory / MMIO responder.
//   Provides the MMIO word offsets relative to MMIO_BASE, the STATUS bit layout,
//   the drop-counter width, and small helper functions used by the top level.
//   Optional feature macro (used by the top level): DMEM_MMIO_CYCLE_COUNTER_EN.
package dmem_mmio_pkg;

  // MMIO word offsets from MMIO_BASE
  localparam int OFS_TXDATA = 0;
  localparam int OFS_STATUS = 1;
  localparam int OFS_DROPS  = 2;
  localparam int OFS_CYCLES = 3;

  // STATUS register bit positions
  localparam int ST_FULL      = 0;
  localparam int ST_EMPTY     = 1;
  localparam int ST_COUNT_LSB = 8;

  // Width of the saturating drop counter
  localparam int DROP_W = 16;

  // Assemble the STATUS word; all unlisted bits read as zero.
  function automatic logic [31:0] pack_status(input logic [7:0] count,
                                              input logic       empty,
                                              input logic       full);
    logic [31:0] v;
    v                       = 32'h0000_0000;
    v[ST_COUNT_LSB +: 8]    = count;
    v[ST_EMPTY]             = empty;
    v[ST_FULL]              = full;
    return v;
  endfunction

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
    logic [DROP_W-1:0] r;
    if (v == {DROP_W{1'b1}}) begin
      r = v;
    end else begin
      r = v + DROP_W'(1);
    end
    return r;
  endfunction

endpackage

// File: rtl/tx_byte_fifo.sv
// tx_byte_fifo
//   Byte-wide synchronous FIFO used as the MMIO transmit queue.
//   Push is accepted when not full, or when full but a pop happens on the same
//   edge (the freed slot is reused, count unchanged). Pop is ignored when empty.
//   o_dout shows the head entry while non-empty and 0 while empty.
// Ports
//   i_clk    clock, state updates on rising edge
//   i_rst    synchronous active-high reset (empties the FIFO)
//   i_push   push request, i_din the byte to push
//   i_pop    pop request
//   o_full   FIFO holds DEPTH entries
//   o_empty  FIFO holds no entries
//   o_dout   head byte (0 while empty)
//   o_count  number of stored entries, clog2(DEPTH)+1 bits
module tx_byte_fifo
  import dmem_mmio_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_push,
  input  logic [7:0]               i_din,
  input  logic                     i_pop,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [7:0]               o_dout,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [7:0]       r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic w_do_push;
  logic w_do_pop;

  assign o_full    = (r_count == CNT_W'(DEPTH));
  assign o_empty   = (r_count == CNT_W'(0));
  assign o_count   = r_count;
  assign w_do_pop  = i_pop & ~o_empty;
  // A full FIFO still accepts when the head leaves on the same edge.
  assign w_do_push = i_push & (~o_full | w_do_pop);
  assign o_dout    = o_empty ? 8'h00 : r_mem[r_rd_ptr];

  // Pointer and occupancy registers; pointers wrap naturally (DEPTH is 2^n).
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= PTR_W'(0);
      r_rd_ptr <= PTR_W'(0);
      r_count  <= CNT_W'(0);
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage array; contents need no reset because occupancy gates visibility.
  always_ff @(posedge i_clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_din;
    end
  end

endmodule

// File: rtl/dmem_mmio_responder.sv
// dmem_mmio_responder
//   Responder for the processor data-memory port. Word addresses below
//   MMIO_BASE hit a 32-bit RAM; addresses from MMIO_BASE upward form an MMIO
//   window: +0 TX_DATA (push byte), +1 STATUS, +2 DROPS, +3 CYCLES.
//   Every cycle performs a read; q_dmem is registered (latency 1). A RAM read
//   that coincides with a write to the same word returns the old contents.
//   Optional feature macro: DMEM_MMIO_CYCLE_COUNTER_EN adds a 32-bit
//   free-running cycle counter at +3; without it +3 reads as 0.
// Ports
//   clock         rising-edge clock
//   reset         synchronous active-high reset (RAM contents are kept)
//   address_dmem  word address
//   data          write data
//   wren          write enable
//   q_dmem        registered read data
//   tx_data       TX FIFO head byte (0 while empty)
//   tx_valid      TX FIFO non-empty
//   tx_ready      consumer accepts head this cycle
module dmem_mmio_responder
  import dmem_mmio_pkg::*;
#(
  parameter int                ADDR_W     = 12,
  parameter int                FIFO_DEPTH = 8,
  parameter logic [ADDR_W-1:0] MMIO_BASE  = 12'hFF0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] address_dmem,
  input  logic [31:0]       data,
  input  logic              wren,
  output logic [31:0]       q_dmem,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready
);

  localparam int CNT_W     = $clog2(FIFO_DEPTH) + 1;
  localparam int RAM_WORDS = int'(MMIO_BASE);

  logic [31:0]       r_ram [RAM_WORDS];
  logic [31:0]       r_q;
  logic [DROP_W-1:0] r_drop_cnt;
`ifdef DMEM_MMIO_CYCLE_COUNTER_EN
  logic [31:0]       r_cycles;
`endif

  logic              w_is_mmio;
  logic [ADDR_W-1:0] w_ofs;
  logic [ADDR_W-1:0] w_ram_idx;
  logic              w_sel_tx;
  logic              w_sel_drops;
  logic              w_push;
  logic              w_pop;
  logic              w_drop;
  logic              w_full;
  logic              w_empty;
  logic [CNT_W-1:0]  w_count;
  logic [31:0]       w_rd_data;

  assign w_is_mmio   = (address_dmem >= MMIO_BASE);
  assign w_ofs       = address_dmem - MMIO_BASE;
  // Keep the RAM index in range when the address falls in the MMIO window.
  assign w_ram_idx   = w_is_mmio ? ADDR_W'(0) : address_dmem;
  assign w_sel_tx    = w_is_mmio & (w_ofs == ADDR_W'(OFS_TXDATA));
  assign w_sel_drops = w_is_mmio & (w_ofs == ADDR_W'(OFS_DROPS));
  assign w_push      = wren & w_sel_tx;
  assign w_pop       = tx_valid & tx_ready;
  // Only a push into a full FIFO with no simultaneous pop is lost.
  assign w_drop      = w_push & w_full & ~w_pop;
  assign tx_valid    = ~w_empty;
  assign q_dmem      = r_q;

  tx_byte_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_tx_fifo (
    .i_clk   (clock),
    .i_rst   (reset),
    .i_push  (w_push),
    .i_din   (data[7:0]),
    .i_pop   (w_pop),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_dout  (tx_data),
    .o_count (w_count)
  );

  // Word RAM write port; not cleared by reset.
  always_ff @(posedge clock) begin
    if (wren & ~w_is_mmio) begin
      r_ram[w_ram_idx] <= data;
    end
  end

  // Read mux built from pre-edge state of RAM and MMIO registers.
  always_comb begin
    w_rd_data = 32'h0000_0000;
    if (!w_is_mmio) begin
      w_rd_data = r_ram[w_ram_idx];
    end else begin
      case (w_ofs)
        ADDR_W'(OFS_STATUS): w_rd_data = pack_status(8'(w_count), w_empty, w_full);
        ADDR_W'(OFS_DROPS):  w_rd_data = 32'(r_drop_cnt);
`ifdef DMEM_MMIO_CYCLE_COUNTER_EN
        ADDR_W'(OFS_CYCLES): w_rd_data = r_cycles;
`else
        ADDR_W'(OFS_CYCLES): w_rd_data = 32'h0000_0000;
`endif
        default:             w_rd_data = 32'h0000_0000;
      endcase
    end
  end

  // Registered read data.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_q <= 32'h0000_0000;
    end else begin
      r_q <= w_rd_data;
    end
  end

  // Drop counter: a write to DROPS clears it, otherwise saturating count of lost pushes.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_drop_cnt <= DROP_W'(0);
    end else if (wren & w_sel_drops) begin
      r_drop_cnt <= DROP_W'(0);
    end else if (w_drop) begin
      r_drop_cnt <= sat_inc(r_drop_cnt);
    end else begin
      r_drop_cnt <= r_drop_cnt;
    end
  end

`ifdef DMEM_MMIO_CYCLE_COUNTER_EN
  // Free-running cycle counter, wraps at 2^32.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_cycles <= 32'h0000_0000;
    end else begin
      r_cycles <= r_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dmem_mmio_responder.sv
// tb_dmem_mmio_responder
//   Self-checking bench: a directed vector table, hand sequences for the FIFO
//   corner cases, and a randomized run compared against a queue-based model.
//   Honours DMEM_MMIO_CYCLE_COUNTER_EN when predicting CYCLES reads.
module tb_dmem_mmio_responder;

  localparam int          DEPTH = 8;
  localparam logic [11:0] BASE  = 12'hFF0;

  logic        clock;
  logic        reset;
  logic [11:0] address_dmem;
  logic [31:0] data;
  logic        wren;
  logic [31:0] q_dmem;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [31:0] m_ram [int];
  logic [7:0]  m_fifo [$];
  int          m_drops;
  logic [31:0] m_cyc;

  dmem_mmio_responder #(
    .ADDR_W     (12),
    .FIFO_DEPTH (DEPTH),
    .MMIO_BASE  (BASE)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .address_dmem (address_dmem),
    .data         (data),
    .wren         (wren),
    .q_dmem       (q_dmem),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2ms;
    $display("FAIL watchdog: time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock cycle: predict from the model, apply inputs, compare after the edge.
  task automatic cycle(input logic rst, input logic [11:0] a, input logic [31:0] d,
                       input logic w, input logic r);
    logic [31:0] eq;
    bit          known;
    bit          pop;
    int          sz;
    known = 1'b1;
    eq    = 32'h0;
    sz    = m_fifo.size();
    if (rst) begin
      m_fifo.delete();
      m_drops = 0;
      m_cyc   = 32'h0;
    end else begin
      if (a < BASE) begin
        if (m_ram.exists(int'(a))) eq = m_ram[int'(a)];
        else known = 1'b0;
      end else begin
        case (int'(a - BASE))
          1: eq = 32'(sz * 256 + (sz == 0 ? 2 : 0) + (sz == DEPTH ? 1 : 0));
          2: eq = 32'(m_drops);
`ifdef DMEM_MMIO_CYCLE_COUNTER_EN
          3: eq = m_cyc;
`endif
          default: eq = 32'h0;
        endcase
      end
      pop = (sz > 0) && r;
      if (pop) void'(m_fifo.pop_front());
      if (w && a == BASE) begin
        if (sz < DEPTH || pop) m_fifo.push_back(d[7:0]);
        else if (m_drops < 65535) m_drops++;
      end
      if (w && a == BASE + 12'd2) m_drops = 0;
      m_cyc = m_cyc + 32'd1;
    end
    if (w && a < BASE) m_ram[int'(a)] = d;

    reset = rst; address_dmem = a; data = d; wren = w; tx_ready = r;
    @(posedge clock);
    #1;
    if (known) check("model_q", q_dmem, eq);
    check("model_valid", 32'(tx_valid), 32'(m_fifo.size() > 0));
    check("model_txdata", 32'(tx_data), 32'(m_fifo.size() > 0 ? m_fifo[0] : 8'h00));
  endtask

  typedef struct {
    logic [11:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic        rdy;
    logic        chk_q;
    logic [31:0] exp_q;
    logic        exp_valid;
    logic [7:0]  exp_tx;
  } vec_t;

  vec_t vecs [12];

  initial begin
    logic [31:0] c0;
    logic [31:0] c1;
    logic [11:0] ra;

    reset = 1'b1; address_dmem = 12'h000; data = 32'h0; wren = 1'b0; tx_ready = 1'b0;
    m_drops = 0; m_cyc = 32'h0;

    cycle(1'b1, 12'h000, 32'h0, 1'b0, 1'b0);
    cycle(1'b1, 12'h000, 32'h0, 1'b0, 1'b0);
    check("reset_q", q_dmem, 32'h0);
    check("reset_valid", 32'(tx_valid), 32'h0);
    check("reset_txdata", 32'(tx_data), 32'h0);

    // Directed table: RAM read-during-write, then three TX pushes and a drain.
    vecs[0]  = '{12'h010, 32'h1111_1111, 1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 8'h00};
    vecs[1]  = '{12'h010, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b1, 32'h1111_1111, 1'b0, 8'h00};
    vecs[2]  = '{12'h010, 32'h0,         1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 8'h00};
    vecs[3]  = '{12'hFF0, 32'h0000_0041, 1'b1, 1'b0, 1'b1, 32'h0,         1'b1, 8'h41};
    vecs[4]  = '{12'hFF0, 32'h0000_0042, 1'b1, 1'b0, 1'b1, 32'h0,         1'b1, 8'h41};
    vecs[5]  = '{12'hFF0, 32'h0000_0043, 1'b1, 1'b0, 1'b1, 32'h0,         1'b1, 8'h41};
    vecs[6]  = '{12'hFF1, 32'h0,         1'b0, 1'b0, 1'b1, 32'h0000_0300, 1'b1, 8'h41};
    vecs[7]  = '{12'hFF5, 32'h0,         1'b0, 1'b1, 1'b1, 32'h0,         1'b1, 8'h42};
    vecs[8]  = '{12'hFF5, 32'h0,         1'b0, 1'b1, 1'b1, 32'h0,         1'b1, 8'h43};
    vecs[9]  = '{12'hFF5, 32'h0,         1'b0, 1'b1, 1'b1, 32'h0,         1'b0, 8'h00};
    vecs[10] = '{12'hFF1, 32'h0,         1'b0, 1'b0, 1'b1, 32'h0000_0002, 1'b0, 8'h00};
    vecs[11] = '{12'hFF2, 32'h0,         1'b0, 1'b0, 1'b1, 32'h0,         1'b0, 8'h00};
    for (int i = 0; i < 12; i++) begin
      cycle(1'b0, vecs[i].addr, vecs[i].wdata, vecs[i].we, vecs[i].rdy);
      if (vecs[i].chk_q) check($sformatf("vec%0d_q", i), q_dmem, vecs[i].exp_q);
      check($sformatf("vec%0d_valid", i), 32'(tx_valid), 32'(vecs[i].exp_valid));
      check($sformatf("vec%0d_tx", i), 32'(tx_data), 32'(vecs[i].exp_tx));
    end

    // Overflow: nine pushes into an 8-deep FIFO, one drop, drain in order.
    for (int i = 0; i < 9; i++) cycle(1'b0, BASE, 32'(8'h60 + i), 1'b1, 1'b0);
    cycle(1'b0, 12'hFF1, 32'h0, 1'b0, 1'b0);
    check("ovf_status", q_dmem, 32'h0000_0801);
    cycle(1'b0, 12'hFF2, 32'h0, 1'b0, 1'b0);
    check("ovf_drops", q_dmem, 32'h0000_0001);
    for (int i = 0; i < 8; i++) begin
      check("ovf_order", 32'(tx_data), 32'(8'h60 + i));
      cycle(1'b0, 12'hFF4, 32'h0, 1'b0, 1'b1);
    end
    check("ovf_empty", 32'(tx_valid), 32'h0);

    // Full FIFO with simultaneous pop and push: accepted, count stays 8.
    for (int i = 0; i < 8; i++) cycle(1'b0, BASE, 32'(8'h70 + i), 1'b1, 1'b0);
    cycle(1'b0, BASE, 32'h0000_0055, 1'b1, 1'b1);
    cycle(1'b0, 12'hFF1, 32'h0, 1'b0, 1'b0);
    check("fullpp_status", q_dmem, 32'h0000_0801);
    cycle(1'b0, 12'hFF2, 32'h0, 1'b0, 1'b0);
    check("fullpp_drops", q_dmem, 32'h0000_0001);
    cycle(1'b0, 12'hFF2, 32'h1234_5678, 1'b1, 1'b0);
    cycle(1'b0, 12'hFF2, 32'h0, 1'b0, 1'b0);
    check("drops_clear", q_dmem, 32'h0);
    for (int i = 0; i < 8; i++) begin
      check("fullpp_order", 32'(tx_data), (i < 7) ? 32'(8'h71 + i) : 32'h55);
      cycle(1'b0, 12'hFF4, 32'h0, 1'b0, 1'b1);
    end
    check("fullpp_empty", 32'(tx_valid), 32'h0);

    // Reset during a drain: FIFO empties, RAM keeps its contents.
    cycle(1'b0, 12'h020, 32'hCAFE_F00D, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) cycle(1'b0, BASE, 32'(8'h81 + i), 1'b1, 1'b0);
    cycle(1'b0, 12'hFF4, 32'h0, 1'b0, 1'b1);
    cycle(1'b0, 12'hFF4, 32'h0, 1'b0, 1'b1);
    cycle(1'b1, 12'hFF4, 32'h0, 1'b0, 1'b1);
    check("rst_drain_valid", 32'(tx_valid), 32'h0);
    cycle(1'b0, 12'hFF1, 32'h0, 1'b0, 1'b0);
    check("rst_drain_status", q_dmem, 32'h0000_0002);
    cycle(1'b0, 12'h020, 32'h0, 1'b0, 1'b0);
    check("rst_drain_ram", q_dmem, 32'hCAFE_F00D);

    // Cycle counter: reads ten edges apart.
    cycle(1'b0, 12'hFF3, 32'hFFFF_FFFF, 1'b1, 1'b0);
    c0 = q_dmem;
    for (int i = 0; i < 9; i++) cycle(1'b0, 12'hFF4, 32'h0, 1'b0, 1'b0);
    cycle(1'b0, 12'hFF3, 32'h0, 1'b0, 1'b0);
    c1 = q_dmem;
`ifdef DMEM_MMIO_CYCLE_COUNTER_EN
    check("cycles_delta", c1 - c0, 32'd10);
`else
    check("cycles_zero0", c0, 32'h0);
    check("cycles_zero1", c1, 32'h0);
`endif

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      case ($urandom_range(0, 3))
        0:       ra = 12'(($urandom_range(0, 15)));
        1, 3:    ra = BASE;
        default: ra = BASE + 12'($urandom_range(0, 7));
      endcase
      cycle(($urandom_range(0, 299) == 0), ra, $urandom, 1'($urandom_range(0, 1)),
            ($urandom_range(0, 9) < ((i < 1500) ? 2 : 7)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
